// File: rtl/reg_file_32x64.sv
// reg_file_32x64: architectural register file for the decode stage.
// 32 x DATA_WIDTH flops, one synchronous write port, two combinational
// read ports built from per-bit 32:1 muxes, hardwired zero register and
// same-cycle write-to-read bypass.

// mux_32_1: single-bit 32:1 selector, one instance per read-port bit.
module mux_32_1 (
  input  logic [31:0] data,
  input  logic [4:0]  sel,
  output logic        out
);

  assign out = data[sel];

endmodule

module reg_file_32x64 #(
  parameter int DATA_WIDTH = 64,
  parameter int ZERO_REG   = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reg_write,
  input  logic [4:0]            write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [4:0]            read_register1,
  input  logic [4:0]            read_register2,
  output logic [DATA_WIDTH-1:0] read_data1,
  output logic [DATA_WIDTH-1:0] read_data2
);

  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [DATA_WIDTH-1:0] regs    [32];
  logic [DATA_WIDTH-1:0] regs_rd [32];
  logic [31:0]           write_en;
  logic [31:0]           column  [DATA_WIDTH];
  logic [DATA_WIDTH-1:0] mux_out1;
  logic [DATA_WIDTH-1:0] mux_out2;
  logic                  bypass1;
  logic                  bypass2;

  // One-hot write decode gated by reg_write; the zero register never gets
  // an enable. Comparing against each index (rather than indexing by
  // write_register) keeps an undriven index harmless while reg_write is low.
  always_comb begin
    write_en = '0;
    for (int i = 0; i < 32; i++) begin
      write_en[i] = reg_write && (write_register == 5'(i)) && (i != ZERO_REG);
    end
  end

  // Register storage: async clear, per-register enable, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (write_en[i]) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  // Read view of storage with the zero register tied to constant 0, so the
  // mux input for that index is a constant regardless of the flop contents.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_rd[i] = (i == ZERO_REG) ? '0 : regs[i];
    end
  end

  // Transpose storage into per-bit columns feeding the 32:1 muxes.
  always_comb begin
    for (int b = 0; b < DATA_WIDTH; b++) begin
      column[b] = '0;
      for (int i = 0; i < 32; i++) begin
        column[b][i] = regs_rd[i][b];
      end
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < DATA_WIDTH; gb++) begin : g_bit
      mux_32_1 u_mux_p1 (
        .data (column[gb]),
        .sel  (read_register1),
        .out  (mux_out1[gb])
      );
      mux_32_1 u_mux_p2 (
        .data (column[gb]),
        .sel  (read_register2),
        .out  (mux_out2[gb])
      );
    end
  endgenerate

  // Bypass: a read of the register being written this cycle returns the
  // incoming data. Never applies to the zero register; ports are independent.
  always_comb begin
    bypass1 = reg_write && (write_register == read_register1) && (read_register1 != ZERO_IDX);
    bypass2 = reg_write && (write_register == read_register2) && (read_register2 != ZERO_IDX);
  end

  // Final read-port select between bypass data and the mux output.
  always_comb begin
    read_data1 = bypass1 ? write_data : mux_out1;
    read_data2 = bypass2 ? write_data : mux_out2;
  end

endmodule

// File: tb/tb_reg_file_32x64.sv
module tb_reg_file_32x64;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [63:0] write_data;
  logic [4:0]  read_register1;
  logic [4:0]  read_register2;
  logic [63:0] read_data1;
  logic [63:0] read_data2;

  reg_file_32x64 dut (
    .clk            (clk),
    .reset          (reset),
    .reg_write      (reg_write),
    .write_register (write_register),
    .write_data     (write_data),
    .read_register1 (read_register1),
    .read_register2 (read_register2),
    .read_data1     (read_data1),
    .read_data2     (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e2;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [63:0] model [32];

  // Reference: what a read returns given architectural state and current inputs.
  function automatic logic [63:0] expect_read(input logic [4:0] rr);
    if (reg_write && write_register == rr && rr != 5'd31) return write_data;
    if (rr == 5'd31) return 64'd0;
    return model[rr];
  endfunction

  // Monitor: the DUT output is valid mid-cycle; compare against everything queued.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (read_data1 !== e.e1) begin
        bad++;
        $display("FAIL %s port1 got=%h exp=%h", e.name, read_data1, e.e1);
      end
      total++;
      if (read_data2 !== e.e2) begin
        bad++;
        $display("FAIL %s port2 got=%h exp=%h", e.name, read_data2, e.e2);
      end
    end
  end

  // Called at posedge+1: drive a cycle, queue the expected reads, then apply
  // the architectural effect of the closing edge to the model.
  task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                      input logic [63:0] wd, input logic [4:0] r1,
                      input logic [4:0] r2, input string name);
    exp_t e;
    reset          = rst;
    reg_write      = we;
    write_register = wr;
    write_data     = wd;
    read_register1 = r1;
    read_register2 = r2;
    if (rst) foreach (model[i]) model[i] = 64'd0;
    #0;
    e.name = name;
    e.e1   = expect_read(r1);
    e.e2   = expect_read(r2);
    sb.push_back(e);
    @(posedge clk);
    if (reset) foreach (model[i]) model[i] = 64'd0;
    else if (reg_write && write_register != 5'd31) model[write_register] = write_data;
    #1;
  endtask

  initial begin
    foreach (model[i]) model[i] = 64'd0;
    reset = 1'b1; reg_write = 1'b0; write_register = '0; write_data = '0;
    read_register1 = '0; read_register2 = '0;
    @(posedge clk); #1;

    step(1, 0, 0, 0, 0, 31, "reset_held");
    step(0, 1, 5, 64'h1234, 5, 6, "preload5");
    step(0, 0, 0, 0, 5, 5, "read5");
    step(1, 0, 0, 0, 5, 5, "async_reset5");
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 5'(i), 5'(31 - i), "reset_all");
    step(0, 0, 0, 0, 5, 0, "release");

    for (int i = 0; i < 31; i++)
      step(0, 1, 5'(i), 64'(i) * 64'h0101010101010101, 5'(i), 31, "sweep_wr");
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 5'(i), 5'(31 - i), "sweep_rd");

    step(0, 1, 31, 64'hFFFFFFFFFFFFFFFF, 31, 31, "zero_wr");
    step(0, 0, 31, 64'hFFFFFFFFFFFFFFFF, 31, 31, "zero_rd");

    step(0, 1, 7, 64'hAAAA, 0, 0, "pre7");
    step(0, 1, 7, 64'h5555, 7, 8, "bypass");
    step(0, 0, 7, 64'h0, 7, 8, "after_bypass");

    for (int i = 0; i < 4; i++) step(0, 0, 3, 64'hDEAD, 3, 3, "wr_disabled");

    step(0, 1, 2, 64'h7777, 9, 9, "pre2");
    step(1, 1, 2, 64'hBEEF, 2, 3, "reset_during_wr");
    step(0, 0, 2, 64'hBEEF, 2, 2, "after_release");
    step(0, 1, 2, 64'hBEEF, 2, 1, "first_wr_after");
    step(0, 0, 0, 0, 2, 2, "readback2");

    for (int n = 0; n < 400; n++) begin
      logic [4:0] wr;
      logic [4:0] r1;
      wr = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), 1'($urandom), wr, {$urandom, $urandom},
           r1, 5'($urandom_range(0, 31)), "random");
    end

    @(negedge clk); #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
